// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks.
// State encoding, frame length and the frame parity helper.
package ps2_pkg;

   // Start + 8 data + parity + stop
   localparam int FRAME_BITS = 11;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_REL
   } ps2_state_e;

   // Parity bit that makes data+parity carry an odd number of ones
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the PS/2 clock and data lines and strobes clock falls.
// Ports: clk_i, reset_i, ps2_clk_i, ps2_data_i -> clk_s_o, data_s_o, fall_o.
module ps2_line_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_s_o,
   output logic data_s_o,
   output logic fall_o
);

   // Bit 0 is the newest sample; reset to the idle (high) line level
   logic [2:0] clk_sync_q;
   logic [1:0] data_sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
      end
   end

   assign clk_s_o  = clk_sync_q[1];
   assign data_s_o = data_sync_q[1];
   assign fall_o   = clk_sync_q[2] & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, shift, ack).
// Ports: clk, reset, ps2_clk/ps2_data in; tx_data/tx_valid/tx_ready; line drives; done/ack_ok/err_timeout.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int REQ_CYCLES     = 100,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       ps2_clk_low,
   output logic       ps2_data_low,
   output logic       done,
   output logic       ack_ok,
   output logic       err_timeout
);

   localparam int PMAX = (INHIBIT_CYCLES > REQ_CYCLES) ?
                         INHIBIT_CYCLES : REQ_CYCLES;
   localparam int PW   = $clog2(PMAX + 1);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
   localparam logic [PW-1:0] REQ_LAST = PW'(REQ_CYCLES - 1);
   localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CYCLES);
   localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 2);

   logic clk_s;
   logic data_s;
   logic fall;

   ps2_line_sync u_sync (
      .clk_i      (clk),
      .reset_i    (reset),
      .ps2_clk_i  (ps2_clk),
      .ps2_data_i (ps2_data),
      .clk_s_o    (clk_s),
      .data_s_o   (data_s),
      .fall_o     (fall)
   );

   ps2_state_e state_q, state_d;
   // {stop, parity, data[7:0]}; start bit is driven directly
   logic [FRAME_BITS-2:0] frame_q, frame_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [TW-1:0] tmo_inc;
   logic [3:0]    bit_q, bit_d;
   logic          ack_rec_q, ack_rec_d;
   logic          ready_q, ready_d;
   logic          clk_low_q, clk_low_d;
   logic          data_low_q, data_low_d;
   logic          done_q, done_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          busy;

   assign tmo_inc = tmo_q + 1'b1;
   assign busy    = (state_q == SHIFT) || (state_q == ACK) ||
                    (state_q == WAIT_REL);

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      phase_d    = phase_q;
      tmo_d      = tmo_q;
      bit_d      = bit_q;
      ack_rec_d  = ack_rec_q;
      clk_low_d  = clk_low_q;
      data_low_d = data_low_q;
      done_d     = 1'b0;
      ack_d      = ack_q;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               frame_d   = {1'b1, odd_parity(tx_data), tx_data};
               phase_d   = '0;
               clk_low_d = 1'b1;
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (phase_q == INH_LAST) begin
               phase_d    = '0;
               data_low_d = 1'b1;
               state_d    = REQ;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         REQ: begin
            if (phase_q == REQ_LAST) begin
               phase_d   = '0;
               clk_low_d = 1'b0;
               bit_d     = '0;
               tmo_d     = '0;
               state_d   = SHIFT;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         SHIFT: begin
            if (fall) begin
               data_low_d = ~frame_q[bit_q];
               bit_d      = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  state_d = ACK;
               end
            end
         end
         ACK: begin
            if (fall) begin
               ack_rec_d = ~data_s;
               state_d   = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (clk_s && data_s) begin
               done_d  = 1'b1;
               ack_d   = ack_rec_q;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides any same-cycle progress once the device stalls
      if (busy) begin
         tmo_d = tmo_inc;
         if (tmo_inc == TMO_END) begin
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            done_d     = 1'b1;
            ack_d      = 1'b0;
            err_d      = 1'b1;
            state_d    = IDLE;
         end
      end

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         frame_q    <= '0;
         phase_q    <= '0;
         tmo_q      <= '0;
         bit_q      <= '0;
         ack_rec_q  <= 1'b0;
         ready_q    <= 1'b1;
         clk_low_q  <= 1'b0;
         data_low_q <= 1'b0;
         done_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         phase_q    <= phase_d;
         tmo_q      <= tmo_d;
         bit_q      <= bit_d;
         ack_rec_q  <= ack_rec_d;
         ready_q    <= ready_d;
         clk_low_q  <= clk_low_d;
         data_low_q <= data_low_d;
         done_q     <= done_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   assign tx_ready     = ready_q;
   assign ps2_clk_low  = clk_low_q;
   assign ps2_data_low = data_low_q;
   assign done         = done_q;
   assign ack_ok       = ack_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus, device model clocking at 1/40 clk.
// Table vectors, random transfers vs. a frame model, and corner sequences.
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_low;
   logic       ps2_data_low;
   logic       done;
   logic       ack_ok;
   logic       err_timeout;

   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;

   assign ps2_clk  = ~(ps2_clk_low | dev_clk_low);
   assign ps2_data = ~(ps2_data_low | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (20),
      .REQ_CYCLES     (4),
      .TIMEOUT_CYCLES (2000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .ps2_clk_low  (ps2_clk_low),
      .ps2_data_low (ps2_data_low),
      .done         (done),
      .ack_ok       (ack_ok),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int done_cnt = 0;
   logic last_ack = 1'b0;
   logic last_err = 1'b0;

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         last_ack = ack_ok;
         last_err = err_timeout;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   // Frame as the device should see it: D0..D7, odd parity, stop
   function automatic logic [9:0] ref_frame(input logic [7:0] d);
      logic par;
      par = (($countones(d) % 2) == 0);
      return {1'b1, par, d};
   endfunction

   task automatic send(input logic [7:0] d);
      int g = 0;
      while (!tx_ready && g < 1000) begin
         @(negedge clk);
         g++;
      end
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   // Send d, measure the inhibit/request phases, then act as the device
   // for nedges clock pulses (edge 11 carries the ack when ack=1).
   task automatic xfer(input logic [7:0] d, input bit ack,
                       input int nedges, input bit poke,
                       output logic [9:0] bits, output int inh,
                       output int req, output logic start,
                       output int rdy_bad);
      int g = 0;
      bits = '0;
      inh = 0;
      req = 0;
      rdy_bad = 0;
      send(d);
      while (ps2_clk_low && !ps2_data_low && g < 5000) begin
         if (tx_ready) rdy_bad++;
         tx_valid = poke && (inh == 5);
         tx_data  = 8'h55;
         inh++;
         g++;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      while (ps2_clk_low && ps2_data_low && g < 5000) begin
         if (tx_ready) rdy_bad++;
         req++;
         g++;
         @(negedge clk);
      end
      start = ps2_data;
      if (nedges == 0) return;
      repeat (10) @(negedge clk);
      for (int e = 1; e <= nedges; e++) begin
         if (e == 11 && ack) begin
            dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         if (e <= 10) begin
            bits[e-1] = ps2_data;
            if (tx_ready) rdy_bad++;
         end
         dev_clk_low  = 1'b0;
         dev_data_low = 1'b0;
         repeat (20) @(negedge clk);
      end
   endtask

   task automatic wait_done(input int c0);
      int g = 0;
      while (done_cnt == c0 && g < 200) begin
         @(negedge clk);
         g++;
      end
   endtask

   task automatic run_full(input string tag, input logic [7:0] d,
                           input bit ack, input logic [9:0] exp_bits,
                           input bit exp_ack);
      logic [9:0] bits;
      int inh, req, rdy_bad, c0;
      logic start;
      c0 = done_cnt;
      xfer(d, ack, 11, 1'b1, bits, inh, req, start, rdy_bad);
      wait_done(c0);
      chk({tag, "_inhibit"}, inh, 20);
      chk({tag, "_req"}, req, 4);
      chk({tag, "_start"}, start, 0);
      chk({tag, "_bits"}, bits, exp_bits);
      chk({tag, "_ready_low"}, rdy_bad, 0);
      chk({tag, "_done_cnt"}, done_cnt - c0, 1);
      chk({tag, "_ack_ok"}, last_ack, exp_ack);
      chk({tag, "_err"}, last_err, 0);
   endtask

   typedef struct {
      logic [7:0] d;
      bit         ack;
      logic       par;
      bit         exp_ack;
   } vec_t;

   initial begin
      vec_t tbl[5];
      logic [9:0] bits;
      int inh, req, rdy_bad, c0, n, idle_bad;
      logic start;

      tbl[0] = '{8'hED, 1'b1, 1'b1, 1'b1};
      tbl[1] = '{8'h01, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{8'h3C, 1'b0, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {tx_ready, ps2_clk_low, ps2_data_low, done, ack_ok, err_timeout},
          6'b100000);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 5; i++)
         run_full($sformatf("vec%0d", i), tbl[i].d, tbl[i].ack,
                  {1'b1, tbl[i].par, tbl[i].d}, tbl[i].exp_ack);

      // A rejected 0x55 must not start a further transfer
      idle_bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ps2_clk_low || ps2_data_low || !tx_ready) idle_bad++;
      end
      chk("no_stray_tx", idle_bad, 0);

      for (int i = 0; i < 5; i++) begin
         logic [7:0] d;
         bit a;
         d = 8'($urandom);
         a = 1'($urandom);
         run_full($sformatf("rnd%0d", i), d, a, ref_frame(d), a);
      end

      // Device never clocks: abort exactly 2000 cycles after release
      c0 = done_cnt;
      xfer(8'h42, 1'b0, 0, 1'b0, bits, inh, req, start, rdy_bad);
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", n, 2000);
      chk("tmo_flags", {done, err_timeout, ack_ok}, 3'b110);
      chk("tmo_lines", {ps2_clk_low, ps2_data_low}, 2'b00);
      @(negedge clk);
      chk("tmo_done_cnt", done_cnt - c0, 1);

      // Reset after 4 clock pulses of 0xA5
      repeat (5) @(negedge clk);
      c0 = done_cnt;
      xfer(8'hA5, 1'b0, 4, 1'b0, bits, inh, req, start, rdy_bad);
      chk("rst_bits4", bits[3:0], 4'h5);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_lines", {ps2_clk_low, ps2_data_low, tx_ready}, 3'b001);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      chk("rst_no_done", done_cnt - c0, 0);
      run_full("after_rst", 8'hF4, 1'b1, ref_frame(8'hF4), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: sim did not finish");
      $fatal(1);
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, 6000: clk cycles the clock line is held low before request-to-send (at least 100 us).
REQ-002 Parameter REQ_CYCLES, 100: clk cycles both lines are held low before the clock line is released.
REQ-003 Parameter TIMEOUT_CYCLES, 1000000: clk cycles from clock release to completion before abort.
REQ-004 clk  in  1  system clock; one clock only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ps2_clk  in  1  sensed PS/2 clock line (asynchronous).
REQ-007 ps2_data  in  1  sensed PS/2 data line (asynchronous).
REQ-008 tx_data  in  8  command byte to send to the device.
REQ-009 tx_valid  in  1  request; the byte is accepted in a cycle where tx_valid=1 and tx_ready=1.
REQ-010 tx_ready  out  1  high only in IDLE.
REQ-011 ps2_clk_low  out  1  1 = drive the clock line low; 0 = release it (open-drain).
REQ-012 ps2_data_low  out  1  1 = drive the data line low; 0 = release it.
REQ-013 done  out  1  one-cycle pulse at the end of every accepted transfer.
REQ-014 ack_ok  out  1  valid when done=1; 1 = device acknowledge bit sampled low.
REQ-015 err_timeout  out  1  valid when done=1; 1 = transfer aborted by timeout.

Function
REQ-016 ps2_clk SHALL pass through a 3-flop synchronizer, and a falling edge is sync[2]=1 and sync[1]=0; ps2_data SHALL pass through a 2-flop synchronizer.
REQ-017 On accept, the block SHALL latch frame {stop=1, parity=~^tx_data, tx_data[7:0]}, with odd parity across data and parity bits, and enter INHIBIT.
REQ-018 INHIBIT: ps2_clk_low=1 and ps2_data_low=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-019 REQ: ps2_clk_low=1 and ps2_data_low=1 (start bit) for exactly REQ_CYCLES cycles, then SHIFT with ps2_clk_low=0, start bit still driven, edge counter=0, timeout counter=0.
REQ-020 Falling edges detected during INHIBIT or REQ SHALL be ignored.
REQ-021 SHIFT: on falling edges 1..10, ps2_data_low SHALL become the inverse of the next frame bit, LSB first: D0..D7, parity, stop (stop releases the line); the update is registered one cycle after edge detection.
REQ-022 Falling edge 10 SHALL move the block to ACK.
REQ-023 ACK: on the next falling edge (11), the block SHALL record ack_ok = ~synced ps2_data and enter WAIT_REL.
REQ-024 WAIT_REL: when synced ps2_clk=1 and ps2_data=1, the block SHALL pulse done with the recorded ack_ok and err_timeout=0, then return to IDLE.
REQ-025 A NACK (ack bit high) is not an error: done=1, ack_ok=0, err_timeout=0.
REQ-026 If the timeout counter reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_REL, the block SHALL release both lines, pulse done with err_timeout=1 and ack_ok=0, and return to IDLE in that cycle.
REQ-027 tx_valid while tx_ready=0 SHALL be ignored and tx_data is not sampled.
REQ-028 A new accept MAY occur in the cycle after done.
REQ-029 All outputs SHALL be registered; ack_ok and err_timeout hold their value until the next done.

Reset
REQ-030 reset SHALL force IDLE with tx_ready=1, ps2_clk_low=0, ps2_data_low=0, done=0, ack_ok=0, err_timeout=0, and clear all counters and synchronizers to 1 (idle lines).
REQ-031 Reset mid-transfer SHALL release both lines on the next clk edge with no done pulse.

Structure
REQ-032 Package ps2_pkg SHALL hold the state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL), FRAME_BITS=11 and an odd-parity function.
REQ-033 Sub-module ps2_line_sync (synchronizers and falling-edge strobe) SHALL be instantiated here and be reusable by the keyboard receiver.

Verification (bench uses INHIBIT_CYCLES=20, REQ_CYCLES=4, TIMEOUT_CYCLES=2000, and a device model clocking at 1/40 clk)
REQ-034 Send 0xED -> device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; device acks -> done=1, ack_ok=1, err_timeout=0.
REQ-035 Send 0x01, 0x00 and 0xFF back-to-back -> parity 0, 1 and 1 respectively; tx_ready=0 throughout each transfer; a tx_valid pulse mid-transfer with 0x55 is never transmitted.
REQ-036 Device omits ack (data high at edge 11) -> done=1, ack_ok=0, err_timeout=0.
REQ-037 Device never clocks -> exactly 2000 cycles after clock release: done=1, err_timeout=1, ps2_clk_low=0, ps2_data_low=0.
REQ-038 Assert reset after 4 falling edges of 0xA5 -> next cycle ps2_clk_low=0, ps2_data_low=0, tx_ready=1, done never pulses; a following 0xF4 completes with ack_ok=1.
REQ-039 INHIBIT and REQ durations SHALL measure exactly 20 and 4 cycles, with no data-line activity during INHIBIT.
